rand_arbiter: RTL and testbench

RAND_ARBITER -- requirements
Module: rand_arbiter

---
 rtl/rand_pkg.sv | 18 +
 rtl/rand_arbiter_if.sv | 22 ++
 rtl/rand_lfsr32.sv | 24 ++
 rtl/rand_arbiter.sv | 102 ++++++++++
 tb/tb_rand_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared FSM encoding, LFSR constants and step function
package rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h00000001;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/rand_arbiter_if.sv
// rtl/rand_arbiter_if.sv - request/response and reseed signals of the random-word arbiter
interface rand_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] REQ_VALID;
  logic [31:0]        RESP_READ;
  logic [NUM_REQ-1:0] RESP_READ_VALID;
  logic               SEED_WRITE;
  logic [31:0]        SEED_DATA;
  logic               SEED_READY;
  logic               DONE;

  modport master (
    output REQ_VALID, SEED_WRITE, SEED_DATA,
    input  RESP_READ, RESP_READ_VALID, SEED_READY, DONE
  );

  modport slave (
    input  REQ_VALID, SEED_WRITE, SEED_DATA,
    output RESP_READ, RESP_READ_VALID, SEED_READY, DONE
  );
endinterface

// File: rtl/rand_lfsr32.sv
// rtl/rand_lfsr32.sv - 32-bit Galois LFSR with load and advance controls
module rand_lfsr32 import rand_pkg::*; #(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ADVANCE,
  input  logic        LOAD,
  input  logic [31:0] LOAD_DATA,
  output logic [31:0] STATE
);

  // An all-zero state would lock the LFSR, so a zero load falls back to SEED.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STATE <= SEED;
    end else if (LOAD) begin
      STATE <= (LOAD_DATA != 32'h0) ? LOAD_DATA : SEED;
    end else if (ADVANCE) begin
      STATE <= lfsr_next(STATE);
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin arbiter handing out words from one shared LFSR
module rand_arbiter import rand_pkg::*; #(
  parameter int          NUM_REQ = 4,
  parameter logic [31:0] SEED    = DEFAULT_SEED
) (
  input  logic          CLK,
  input  logic          RESET,
  rand_arbiter_if.slave bus
);

  localparam int W = $clog2(NUM_REQ);

  state_t             state, state_nx;
  logic [W-1:0]       winner, last_winner, pick, cand;
  logic               found, grant, lfsr_load, lfsr_adv;
  logic [NUM_REQ-1:0] win_onehot, candidates;
  logic [31:0]        lfsr_state, resp_word;

  rand_lfsr32 #(.SEED(SEED)) u_lfsr (
    .CLK       (CLK),
    .RESET     (RESET),
    .ADVANCE   (lfsr_adv),
    .LOAD      (lfsr_load),
    .LOAD_DATA (bus.SEED_DATA),
    .STATE     (lfsr_state)
  );

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  // The winner still holds its request on the edge leaving RESP, so hide it.
  assign candidates = bus.REQ_VALID & ~((state == ST_RESP) ? win_onehot : '0);

  always_comb begin
    found = 1'b0;
    pick  = last_winner;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = W'((int'(last_winner) + i) % NUM_REQ);
      if (!found && candidates[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.SEED_WRITE) begin
          lfsr_load = 1'b1;
        end else if (found) begin
          grant    = 1'b1;
          state_nx = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        lfsr_adv = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (found) begin
          grant    = 1'b1;
          state_nx = ST_ADVANCE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      winner      <= '0;
      last_winner <= W'(NUM_REQ - 1);
      resp_word   <= 32'h0;
    end else begin
      state <= state_nx;
      if (grant) begin
        winner      <= pick;
        last_winner <= pick;
      end
      if (lfsr_adv) begin
        resp_word <= lfsr_next(lfsr_state);
      end
    end
  end

  assign bus.RESP_READ       = resp_word;
  assign bus.RESP_READ_VALID = (state == ST_RESP) ? win_onehot : '0;
  assign bus.SEED_READY      = (state == ST_IDLE);
  assign bus.DONE            = (state == ST_IDLE) && (bus.REQ_VALID == '0);

endmodule

// File: tb/tb_rand_arbiter.sv
// tb/tb_rand_arbiter.sv - scheduled-response reference model, directed pins and random traffic
module tb_rand_arbiter;

  localparam int          N    = 4;
  localparam logic [31:0] SEED = 32'h00000001;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  rand_arbiter_if #(.NUM_REQ(N)) bus ();

  rand_arbiter #(.NUM_REQ(N), .SEED(SEED)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          idx;
    logic [31:0] word;
    int          cyc;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  resp_t       log_q[$];
  resp_t       r;
  logic [N-1:0] seen, exp_v, pend;
  logic [31:0] m_lfsr, m_word;
  int          m_last, m_win, due;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic int rr(input int last, input logic [N-1:0] p);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Model: a grant sampled on edge g is answered during cycle g+1; 'due' holds that cycle.
  always @(negedge CLK) begin
    if (RESET) begin
      m_lfsr = SEED;
      m_word = 32'h0;
      m_last = N - 1;
      m_win  = 0;
      due    = -100;
      seen   = '0;
    end else begin
      exp_v = '0;
      if (due == cyc) exp_v[m_win] = 1'b1;
      check("resp_valid", 32'(bus.RESP_READ_VALID), 32'(exp_v));
      check("resp_read", bus.RESP_READ, m_word);
      check("seed_ready", 32'(bus.SEED_READY), 32'(due < cyc));
      check("done", 32'(bus.DONE), 32'((due < cyc) && (bus.REQ_VALID == '0)));
      seen = bus.RESP_READ_VALID;
      for (int k = 0; k < N; k++) begin
        if (seen[k]) begin
          r.idx  = k;
          r.word = bus.RESP_READ;
          r.cyc  = cyc;
          log_q.push_back(r);
        end
      end
      if (due == cyc + 1) begin
        m_lfsr = nxt(m_lfsr);
        m_word = m_lfsr;
      end else if (due < cyc) begin
        if (bus.SEED_WRITE) begin
          m_lfsr = (bus.SEED_DATA != 32'h0) ? bus.SEED_DATA : SEED;
        end else if (bus.REQ_VALID != '0) begin
          m_win  = rr(m_last, bus.REQ_VALID);
          m_last = m_win;
          due    = cyc + 2;
        end
      end else if (due == cyc) begin
        pend        = bus.REQ_VALID;
        pend[m_win] = 1'b0;
        if (pend != '0) begin
          m_win  = rr(m_last, pend);
          m_last = m_win;
          due    = cyc + 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    bus.REQ_VALID  = bus.REQ_VALID & ~seen;
    bus.SEED_WRITE = 1'b0;
  endtask

  task automatic do_reset();
    RESET          = 1'b1;
    bus.REQ_VALID  = '0;
    bus.SEED_WRITE = 1'b0;
    bus.SEED_DATA  = 32'h0;
    tick();
    tick();
    RESET = 1'b0;
    log_q.delete();
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic wait_log(input int n, input string name);
    int b = 0;
    while (log_q.size() < n && b < 50) begin
      tick();
      b++;
    end
    check({name, "_timeout"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_resp(input string name, input int i, input int idx,
                            input logic [31:0] word, input int c_exp);
    if (log_q.size() > i) begin
      check({name, "_idx"}, log_q[i].idx, idx);
      check({name, "_word"}, log_q[i].word, word);
      check({name, "_cycle"}, log_q[i].cyc, c_exp);
    end else begin
      check({name, "_missing"}, log_q.size(), i + 1);
    end
  endtask

  initial begin
    int c0;
    int b;
    bus.REQ_VALID  = '0;
    bus.SEED_WRITE = 1'b0;
    bus.SEED_DATA  = 32'h0;
    #12;
    check("rst_valid", 32'(bus.RESP_READ_VALID), 32'h0);
    check("rst_word", bus.RESP_READ, 32'h0);
    check("rst_seed_ready", 32'(bus.SEED_READY), 32'h1);
    check("rst_done", 32'(bus.DONE), 32'h1);

    // single requester: latency, first word, DONE while busy
    do_reset();
    c0 = cyc;
    bus.REQ_VALID = 4'b0001;
    tick();
    check("a_done_busy", 32'(bus.DONE), 32'h0);
    wait_log(1, "a");
    check_resp("a0", 0, 0, 32'h80200003, c0 + 2);
    settle();
    check("a_done_idle", 32'(bus.DONE), 32'h1);

    // all four requesting: served 0..3, two cycles apart
    do_reset();
    c0 = cyc;
    bus.REQ_VALID = 4'b1111;
    wait_log(4, "b");
    check_resp("b0", 0, 0, 32'h80200003, c0 + 2);
    check_resp("b1", 1, 1, 32'hC0300002, c0 + 4);
    check_resp("b2", 2, 2, 32'h60180001, c0 + 6);
    check_resp("b3", 3, 3, 32'hB02C0003, c0 + 8);
    settle();

    // last winner 2, then 1001: requester 3 before 0
    do_reset();
    bus.REQ_VALID = 4'b0100;
    wait_log(1, "c_pre");
    check_resp("c_pre", 0, 2, 32'h80200003, log_q.size() > 0 ? log_q[0].cyc : 0);
    settle();
    log_q.delete();
    c0 = cyc;
    bus.REQ_VALID = 4'b1001;
    wait_log(2, "c");
    check_resp("c0", 0, 3, 32'hC0300002, c0 + 2);
    check_resp("c1", 1, 0, 32'h60180001, c0 + 4);
    settle();

    // reseed, then zero reseed falls back to SEED
    do_reset();
    bus.SEED_WRITE = 1'b1;
    bus.SEED_DATA  = 32'h12345678;
    tick();
    c0 = cyc;
    bus.REQ_VALID = 4'b0001;
    wait_log(1, "d");
    check_resp("d0", 0, 0, 32'h091A2B3C, c0 + 2);
    settle();
    log_q.delete();
    bus.SEED_WRITE = 1'b1;
    bus.SEED_DATA  = 32'h0;
    tick();
    c0 = cyc;
    bus.REQ_VALID = 4'b0001;
    wait_log(1, "d_zero");
    check_resp("d1", 0, 0, 32'h80200003, c0 + 2);
    settle();

    // seed write and request together: seed first, grant one cycle later
    do_reset();
    c0 = cyc;
    bus.SEED_WRITE = 1'b1;
    bus.SEED_DATA  = 32'h12345678;
    bus.REQ_VALID  = 4'b0001;
    wait_log(1, "e");
    check_resp("e0", 0, 0, 32'h091A2B3C, c0 + 3);
    settle();

    // reset during RESP kills the response at once
    do_reset();
    bus.REQ_VALID = 4'b0001;
    tick();
    tick();
    check("f_valid_pre", 32'(bus.RESP_READ_VALID), 32'h1);
    #1;
    RESET = 1'b1;
    #1;
    check("f_valid_reset", 32'(bus.RESP_READ_VALID), 32'h0);
    check("f_word_reset", bus.RESP_READ, 32'h0);
    tick();
    RESET = 1'b0;
    log_q.delete();
    c0 = cyc;
    wait_log(1, "f");
    check_resp("f0", 0, 0, 32'h80200003, c0 + 2);
    settle();

    // random traffic with occasional reseeds, checked cycle by cycle
    do_reset();
    for (int it = 0; it < 800; it++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!bus.REQ_VALID[i] && !seen[i] && $urandom_range(0, 3) == 0) bus.REQ_VALID[i] = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) begin
        bus.SEED_WRITE = 1'b1;
        bus.SEED_DATA  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
    end
    b = 0;
    while (bus.REQ_VALID != '0 && b < 100) begin
      tick();
      b++;
    end
    check("drain", 32'(bus.REQ_VALID == '0), 32'h1);
    settle();
    check("end_done", 32'(bus.DONE), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
